// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: JumpOP codes and FSM states.
package cpu_defs;

  typedef enum logic [1:0] {
    JUMPOP_SEQ = 2'b00,
    JUMPOP_BR  = 2'b01,
    JUMPOP_JR  = 2'b10,
    JUMPOP_J   = 2'b11
  } jump_op_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational JumpOP priority resolution and next-PC target mux.
module next_pc_calc
  import cpu_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0]   pc,
  input  logic              zero,
  input  logic              branch,
  input  logic              jr,
  input  logic              jump,
  input  logic [IMM_W-1:0]  imm16,
  input  logic [JIDX_W-1:0] jidx26,
  input  logic [PC_W-1:0]   jr_addr,
  output logic [1:0]        jump_op,
  output logic [PC_W-1:0]   next_pc,
  output logic              jr_misaligned
);

  // Keeps the upper PC bits when splicing in the 26-bit jump index.
  localparam logic [PC_W-1:0] LOW28_MASK = PC_W'(28'hFFF_FFFF);

  function automatic logic signed [PC_W-1:0] br_offset(input logic [IMM_W-1:0] imm);
    logic signed [PC_W-1:0] ext;
    ext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    return ext <<< 2;
  endfunction

  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jr_tgt;
  logic [PC_W-1:0] j_tgt;

  assign pc4    = pc + PC_W'(4);
  assign br_tgt = pc4 + $unsigned(br_offset(imm16));
  assign jr_tgt = {jr_addr[PC_W-1:2], 2'b00};
  assign j_tgt  = (pc4 & ~LOW28_MASK) | PC_W'({jidx26, 2'b00});

  assign jr_misaligned = |jr_addr[1:0];

  // A taken branch outranks jr, which outranks j/jal.
  always_comb begin
    jump_op = JUMPOP_SEQ;
    if (branch && zero) jump_op = JUMPOP_BR;
    else if (jr)        jump_op = JUMPOP_JR;
    else if (jump)      jump_op = JUMPOP_J;
  end

  always_comb begin
    next_pc = pc4;
    case (jump_op)
      JUMPOP_BR: next_pc = br_tgt;
      JUMPOP_JR: next_pc = jr_tgt;
      JUMPOP_J:  next_pc = j_tgt;
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: BOOT -> FETCH -> EXEC loop, owns the PC and retire counter.
module pc_sequencer
  import cpu_defs::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_ack,
  input  logic              zero,
  input  logic              branch,
  input  logic              jr,
  input  logic              jump,
  input  logic [IMM_W-1:0]  imm16,
  input  logic [JIDX_W-1:0] jidx26,
  input  logic [PC_W-1:0]   jr_addr,
  input  logic              stall,
  input  logic              halt,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  output logic              exec_en,
  output logic              retire,
  output logic [1:0]        jump_op,
  output logic [PC_W-1:0]   pc,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              addr_err,
  output logic              halted
);

  state_e          state;
  logic [1:0]      calc_op;
  logic [PC_W-1:0] next_pc;
  logic            jr_misaligned;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc_calc (
    .pc            (pc),
    .zero          (zero),
    .branch        (branch),
    .jr            (jr),
    .jump          (jump),
    .imm16         (imm16),
    .jidx26        (jidx26),
    .jr_addr       (jr_addr),
    .jump_op       (calc_op),
    .next_pc       (next_pc),
    .jr_misaligned (jr_misaligned)
  );

  // Status outputs decode straight from the state register, so an async reset
  // drops imem_req without waiting for a clock edge.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign exec_en   = (state == ST_EXEC);
  assign halted    = (state == ST_HALT);
  assign retire    = (state == ST_EXEC) && !stall;
  assign jump_op   = (state == ST_EXEC) ? calc_op : JUMPOP_SEQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      instr_cnt <= '0;
      addr_err  <= 1'b0;
    end else begin
      case (state)
        ST_BOOT:  state <= ST_FETCH;
        ST_FETCH: if (imem_ack) state <= ST_EXEC;
        ST_EXEC: begin
          if (!stall) begin
            pc        <= next_pc;
            instr_cnt <= instr_cnt + CNT_W'(1);
            if (calc_op == JUMPOP_JR && jr_misaligned) addr_err <= 1'b1;
            state     <= halt ? ST_HALT : ST_FETCH;
          end
        end
        default:  state <= ST_HALT;
      endcase
    end
  end

endmodule
